// File: rtl/fc2_forward_mac.sv
// Two-lane FC2 forward MAC: streams 5 groups of 64 weight/activation pairs
// through a multiply/accumulate pipeline and emits 10 saturated neuron results.
module fc2_forward_mac #(
  parameter int PREC         = 16,
  parameter int FRAC         = 8,
  parameter int FAN_IN       = 64,
  parameter int HALF_NEURONS = 5,
  parameter int ACC_W        = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [9:0]        w_addr,
  output logic              w_en,
  input  logic [2*PREC-1:0] w_data,
  input  logic [7:0]        w_neuron_id,
  output logic [5:0]        act_idx,
  input  logic [PREC-1:0]   act_in,
  output logic              out_valid,
  output logic [3:0]        out_neuron_id,
  output logic [PREC-1:0]   out_data,
  output logic              busy,
  output logic              done
);

  localparam int TOTAL = FAN_IN * HALF_NEURONS;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PREC+1){1'b0}}, {(PREC-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PREC+1){1'b1}}, {(PREC-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;
  logic [9:0] issue;
  logic [5:0] k;
  logic [2:0] dcnt;

  // stage 1: BRAM/activation data on the inputs; stage 2: product registered
  logic v1, first1, last1;
  logic v2, first2, last2;
  logic signed [2*PREC-1:0] prod0, prod1;
  logic [3:0] nid0, nid1;
  logic signed [ACC_W-1:0] acc0, acc1, acc0_n, acc1_n;

  logic            skid_v;
  logic [3:0]      skid_id;
  logic [PREC-1:0] skid_data;

  function automatic logic [PREC-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > SAT_MAX)      sat = SAT_MAX[PREC-1:0];
    else if (s < SAT_MIN) sat = SAT_MIN[PREC-1:0];
    else                  sat = s[PREC-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (issue == 10'(TOTAL - 1)) state_n = DRAIN;
      DRAIN:   if (dcnt == 3'd3) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      issue <= '0;
      k     <= '0;
    end else begin
      issue <= issue + 10'd1;
      k     <= (k == 6'(FAN_IN - 1)) ? '0 : k + 6'd1;
    end
    if (rst || state != DRAIN) dcnt <= '0;
    else                       dcnt <= dcnt + 3'd1;
  end

  always_comb begin
    w_en    = (state == RUN);
    w_addr  = w_en ? issue : '0;
    act_idx = w_en ? k : '0;
    busy    = (state != IDLE);
    done    = (state == DONE);
  end

  always_comb begin
    acc0_n = first2 ? ACC_W'(prod0) : acc0 + ACC_W'(prod0);
    acc1_n = first2 ? ACC_W'(prod1) : acc1 + ACC_W'(prod1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0;
      v2 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0;
      prod0 <= '0; prod1 <= '0; nid0 <= '0; nid1 <= '0;
      acc0 <= '0; acc1 <= '0;
      skid_v <= 1'b0; skid_id <= '0; skid_data <= '0;
      out_valid <= 1'b0; out_neuron_id <= '0; out_data <= '0;
    end else begin
      v1     <= w_en;
      first1 <= w_en && (k == '0);
      last1  <= w_en && (k == 6'(FAN_IN - 1));
      v2     <= v1;
      first2 <= first1;
      last2  <= last1;
      prod0  <= $signed(w_data[PREC-1:0]) * $signed(act_in);
      prod1  <= $signed(w_data[2*PREC-1:PREC]) * $signed(act_in);
      nid0   <= w_neuron_id[3:0];
      nid1   <= w_neuron_id[7:4];
      if (v2) begin
        acc0 <= acc0_n;
        acc1 <= acc1_n;
      end
      // Results come straight from the final accumulate so lane 0 lands on the
      // same cycle the accumulator shows it; lane 1 waits one cycle in the skid.
      if (v2 && last2) begin
        out_valid     <= 1'b1;
        out_neuron_id <= nid0;
        out_data      <= sat(acc0_n);
        skid_v        <= 1'b1;
        skid_id       <= nid1;
        skid_data     <= sat(acc1_n);
      end else if (skid_v) begin
        out_valid     <= 1'b1;
        out_neuron_id <= skid_id;
        out_data      <= skid_data;
        skid_v        <= 1'b0;
        skid_id       <= '0;
        skid_data     <= '0;
      end else begin
        out_valid     <= 1'b0;
        out_neuron_id <= '0;
        out_data      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fc2_forward_mac.sv
// Directed bench for fc2_forward_mac: BRAM/activation model plus a per-cycle
// expected-output vector for every cycle of each pass.
module tb_fc2_forward_mac;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  w_addr;
  logic        w_en;
  logic [31:0] w_data;
  logic [7:0]  w_neuron_id;
  logic [5:0]  act_idx;
  logic [15:0] act_in;
  logic        out_valid;
  logic [3:0]  out_neuron_id;
  logic [15:0] out_data;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] w0e, w0o, w1e, w1o, a_val;

  always #5 clk = ~clk;

  fc2_forward_mac #(.PREC(16), .FRAC(8), .FAN_IN(64), .HALF_NEURONS(5), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_addr(w_addr), .w_en(w_en), .w_data(w_data), .w_neuron_id(w_neuron_id),
    .act_idx(act_idx), .act_in(act_in),
    .out_valid(out_valid), .out_neuron_id(out_neuron_id), .out_data(out_data),
    .busy(busy), .done(done)
  );

  // Weight BRAM and activation buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (w_en) begin
      w_data      <= {(w_addr[0] ? w1o : w1e), (w_addr[0] ? w0o : w0e)};
      w_neuron_id <= {w_addr[9:6] + 4'd5, w_addr[9:6]};
      act_in      <= a_val;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {24'd0, busy, done, w_en, w_addr, act_idx, out_valid, out_neuron_id, out_data};
  endfunction

  function automatic logic [63:0] exp_vec(int n, logic [15:0] e0, logic [15:0] e1);
    logic        run;
    logic [9:0]  a;
    logic        ov;
    logic [3:0]  id;
    logic [15:0] d;
    run = (n >= 1 && n <= 320);
    a   = run ? 10'(n - 1) : 10'd0;
    ov  = 1'b0; id = 4'd0; d = 16'd0;
    for (int g = 0; g < 5; g++) begin
      if (n == 64*g + 67) begin ov = 1'b1; id = 4'(g);     d = e0; end
      if (n == 64*g + 68) begin ov = 1'b1; id = 4'(g + 5); d = e1; end
    end
    return {24'd0, (n >= 1 && n <= 325), (n == 325), run, a, a[5:0], ov, id, d};
  endfunction

  task automatic run_pass(input string name,
                          input logic [15:0] p0e, input logic [15:0] p0o,
                          input logic [15:0] p1e, input logic [15:0] p1o,
                          input logic [15:0] act, input logic [15:0] e0, input logic [15:0] e1,
                          input bit pulse_busy, input bit chain_in, input bit chain_out);
    int last;
    w0e = p0e; w0o = p0o; w1e = p1e; w1o = p1o; a_val = act;
    if (!chain_in) begin
      @(negedge clk);
      start = 1'b1;
    end
    last = chain_out ? 326 : 330;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      chk($sformatf("%s c%0d", name, n), obs_vec(), exp_vec(n, e0, e1));
      start = (pulse_busy && (n == 50 || n == 325)) || (chain_out && n == 326);
    end
  endtask

  task automatic run_abort();
    w0e = 16'h0100; w0o = 16'h0100; w1e = 16'h0100; w1o = 16'h0100; a_val = 16'h0100;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      chk($sformatf("abort c%0d", n), obs_vec(), exp_vec(n, 16'h4000, 16'h4000));
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort c101", obs_vec(), 64'd0);
    rst = 1'b0;
    for (int n = 102; n <= 335; n++) begin
      @(posedge clk); #1;
      chk($sformatf("abort idle c%0d", n), obs_vec(), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1;
    w_data = '0; w_neuron_id = '0; act_in = '0;
    w0e = '0; w0o = '0; w1e = '0; w1o = '0; a_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset with start", obs_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle after reset", obs_vec(), 64'd0);

    run_pass("unity", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h4000, 16'h4000, 0, 0, 0);
    run_pass("mixed", 16'h0100, 16'h0100, 16'hFF80, 16'hFF80, 16'h0180, 16'h6000, 16'hD000, 0, 0, 0);
    run_pass("sat",   16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 0, 0, 0);
    run_pass("cancel",16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0);
    run_pass("trunc", 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1, 0, 1);
    run_pass("chain", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h4000, 16'h4000, 0, 1, 0);
    run_abort();
    run_pass("post-abort", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h4000, 16'h4000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
